// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared opcode encoding, widths and ALU semantics for datapath and checker
package pipeline_pkg;
  localparam int REGS = 8;
  localparam int XLEN = 32;
  typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_LI} op_e;
  function automatic logic [XLEN-1:0] alu_ref(input op_e op, input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b, input logic [15:0] imm);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SHL:  return a << b[4:0];
      OP_SHR:  return a >> b[4:0];
      default: return {16'd0, imm};
    endcase
  endfunction
endpackage

// File: rtl/pipeline_trace_checker_if.sv
// pipeline_trace_checker_if: issue/retire streams and scoreboard status of the trace checker
interface pipeline_trace_checker_if #(parameter int DEPTH = 4);
  import pipeline_pkg::*;
  localparam int RW = $clog2(REGS);
  logic                   iss_valid;
  logic [2:0]             iss_op;
  logic [RW-1:0]          iss_rd;
  logic [XLEN-1:0]        iss_src1;
  logic [XLEN-1:0]        iss_src2;
  logic [15:0]            iss_imm16;
  logic                   ret_valid;
  logic [RW-1:0]          ret_rd;
  logic [XLEN-1:0]        ret_result;
  logic [31:0]            pass_cnt;
  logic [15:0]            err_cnt;
  logic [XLEN-1:0]        checksum;
  logic [XLEN-1:0]        first_err_exp;
  logic [XLEN-1:0]        first_err_got;
  logic [$clog2(DEPTH):0] in_flight;
  logic                   overflow;
  logic                   underflow;
  logic                   halted;
  modport master (
    output iss_valid, iss_op, iss_rd, iss_src1, iss_src2, iss_imm16, ret_valid, ret_rd, ret_result,
    input  pass_cnt, err_cnt, checksum, first_err_exp, first_err_got, in_flight, overflow, underflow, halted
  );
  modport slave (
    input  iss_valid, iss_op, iss_rd, iss_src1, iss_src2, iss_imm16, ret_valid, ret_rd, ret_result,
    output pass_cnt, err_cnt, checksum, first_err_exp, first_err_got, in_flight, overflow, underflow, halted
  );
endinterface

// File: rtl/pipeline_trace_checker_sync_fifo.sv
// sync_fifo: synchronous FIFO with occupancy counter; push on a full FIFO is legal when popping
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       din_i,
  output logic [WIDTH-1:0]       dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q;
  logic do_push, do_pop;
  assign full_o  = count_q == CW'(DEPTH);
  assign empty_o = count_q == '0;
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = mem_q[rd_q];
  assign count_o = count_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= do_push ? wr_q + AW'(1) : wr_q;
      rd_q    <= do_pop ? rd_q + AW'(1) : rd_q;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end
endmodule

// File: rtl/pipeline_trace_checker.sv
// pipeline_trace_checker: in-order scoreboard comparing retired (rd, result) against results predicted at issue
module pipeline_trace_checker import pipeline_pkg::*; #(
  parameter int DEPTH       = 4,
  parameter bit STOP_ON_ERR = 1
) (
  input logic                     clk,
  input logic                     rst,
  pipeline_trace_checker_if.slave trace_io
);
  localparam int RW = $clog2(REGS);
  localparam int CW = $clog2(DEPTH) + 1;
  typedef enum logic {RUN, HALT} state_e;
  state_e state_q, state_d;
  logic [31:0] pass_q, pass_d;
  logic [15:0] err_q, err_d;
  logic [XLEN-1:0] chk_q, chk_d, fe_exp_q, fe_exp_d, fe_got_q, fe_got_d;
  logic ovf_q, ovf_d, udf_q, udf_d;
  logic [RW+XLEN-1:0] head;
  logic [RW-1:0] head_rd;
  logic [XLEN-1:0] head_res, exp_res;
  logic [CW-1:0] count;
  logic full, empty, pop_ok, hit;
  assign exp_res  = alu_ref(op_e'(trace_io.iss_op), trace_io.iss_src1, trace_io.iss_src2, trace_io.iss_imm16);
  assign head_rd  = head[XLEN+:RW];
  assign head_res = head[XLEN-1:0];
  assign pop_ok   = trace_io.ret_valid && !empty;
  assign hit      = head_rd == trace_io.ret_rd && head_res == trace_io.ret_result;
  sync_fifo #(.WIDTH(RW + XLEN), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (trace_io.iss_valid),
    .pop_i   (pop_ok),
    .din_i   ({trace_io.iss_rd, exp_res}),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      pass_q   <= '0;
      err_q    <= '0;
      chk_q    <= '0;
      fe_exp_q <= '0;
      fe_got_q <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      chk_q    <= chk_d;
      fe_exp_q <= fe_exp_d;
      fe_got_q <= fe_got_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end
  // Queue traffic continues in HALT; only the scoring state is frozen there.
  always_comb begin
    state_d  = state_q;
    pass_d   = pass_q;
    err_d    = err_q;
    chk_d    = chk_q;
    fe_exp_d = fe_exp_q;
    fe_got_d = fe_got_q;
    ovf_d    = ovf_q | (trace_io.iss_valid & full & ~pop_ok);
    udf_d    = udf_q | (trace_io.ret_valid & empty);
    if (pop_ok && state_q == RUN) begin
      chk_d = chk_q ^ trace_io.ret_result;
      if (hit) begin
        pass_d = pass_q + 32'd1;
      end else begin
        err_d = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;
        if (err_q == '0) begin
          fe_exp_d = head_res;
          fe_got_d = trace_io.ret_result;
        end
        if (STOP_ON_ERR) state_d = HALT;
      end
    end
  end
  assign trace_io.pass_cnt      = pass_q;
  assign trace_io.err_cnt       = err_q;
  assign trace_io.checksum      = chk_q;
  assign trace_io.first_err_exp = fe_exp_q;
  assign trace_io.first_err_got = fe_got_q;
  assign trace_io.in_flight     = count;
  assign trace_io.overflow      = ovf_q;
  assign trace_io.underflow     = udf_q;
  assign trace_io.halted        = state_q == HALT;
endmodule

// File: tb/tb_pipeline_trace_checker.sv
// tb_pipeline_trace_checker: vector table, directed corner sequences and random traffic against a queue model
module tb_pipeline_trace_checker;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  pipeline_trace_checker_if #(.DEPTH(DEPTH)) bus ();
  pipeline_trace_checker #(.DEPTH(DEPTH), .STOP_ON_ERR(1)) dut (.clk(clk), .rst(rst), .trace_io(bus));

  typedef struct {logic [2:0] rd; logic [31:0] v;} ent_t;
  typedef struct {logic [2:0] op; logic [31:0] a; logic [31:0] b; logic [15:0] imm; logic [31:0] exp;} vec_t;
  ent_t mq[$];
  logic [31:0] m_pass, m_chk, m_fe_exp, m_fe_got;
  logic [15:0] m_err;
  logic m_ovf, m_udf, m_halt;
  int checks = 0;
  int failures = 0;

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                          input logic [15:0] imm);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a + ~b + 32'd1;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return a << (b % 32);
      3'd6:    return a >> (b % 32);
      default: return {16'd0, imm};
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pass_cnt"}, bus.pass_cnt, m_pass);
    check({tag, ".err_cnt"}, 32'(bus.err_cnt), 32'(m_err));
    check({tag, ".checksum"}, bus.checksum, m_chk);
    check({tag, ".first_err_exp"}, bus.first_err_exp, m_fe_exp);
    check({tag, ".first_err_got"}, bus.first_err_got, m_fe_got);
    check({tag, ".in_flight"}, 32'(bus.in_flight), 32'(mq.size()));
    check({tag, ".overflow"}, 32'(bus.overflow), 32'(m_ovf));
    check({tag, ".underflow"}, 32'(bus.underflow), 32'(m_udf));
    check({tag, ".halted"}, 32'(bus.halted), 32'(m_halt));
  endtask

  task automatic step();
    ent_t e;
    bit popped;
    if (rst) begin
      mq.delete();
      m_pass = 0; m_err = 0; m_chk = 0; m_fe_exp = 0; m_fe_got = 0;
      m_ovf = 0; m_udf = 0; m_halt = 0;
    end else begin
      popped = bus.ret_valid && mq.size() != 0;
      if (bus.ret_valid && !popped) m_udf = 1;
      if (popped) begin
        e = mq.pop_front();
        if (!m_halt) begin
          m_chk ^= bus.ret_result;
          if (e.rd == bus.ret_rd && e.v == bus.ret_result) m_pass++;
          else begin
            if (m_err == 0) begin
              m_fe_exp = e.v;
              m_fe_got = bus.ret_result;
            end
            if (m_err != 16'hFFFF) m_err++;
            m_halt = 1;
          end
        end
      end
      if (bus.iss_valid) begin
        if (mq.size() < DEPTH) mq.push_back('{bus.iss_rd, ref_alu(bus.iss_op, bus.iss_src1, bus.iss_src2, bus.iss_imm16)});
        else m_ovf = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit iv, input logic [2:0] op, input logic [2:0] rd, input logic [31:0] a,
                       input logic [31:0] b, input logic [15:0] imm, input bit rv, input logic [2:0] rrd,
                       input logic [31:0] rres);
    bus.iss_valid = iv; bus.iss_op = op; bus.iss_rd = rd;
    bus.iss_src1 = a; bus.iss_src2 = b; bus.iss_imm16 = imm;
    bus.ret_valid = rv; bus.ret_rd = rrd; bus.ret_result = rres;
  endtask

  task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [31:0] a, input logic [31:0] b,
                       input logic [15:0] imm);
    drive(1, op, rd, a, b, imm, 0, 0, 0);
  endtask

  task automatic retire(input logic [2:0] rd, input logic [31:0] res);
    drive(0, 0, 0, 0, 0, 0, 1, rd, res);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  vec_t vt[9];
  logic [31:0] run_chk;

  initial begin
    idle();
    step();
    step();
    rst = 1'b0;
    check_all("reset");
    check("reset.in_flight_const", 32'(bus.in_flight), 0);

    // three issues then a one-cycle reset: queue and status must be wiped
    for (int i = 0; i < 3; i++) begin
      issue(3'd0, 3'(i), 32'(i), 32'd1, 16'd0);
      step();
    end
    check("midrst.pre_in_flight", 32'(bus.in_flight), 3);
    do_reset();
    check("midrst.in_flight", 32'(bus.in_flight), 0);
    check("midrst.pass", bus.pass_cnt, 0);
    check("midrst.err", 32'(bus.err_cnt), 0);
    check("midrst.flags", {29'd0, bus.overflow, bus.underflow, bus.halted}, 0);
    retire(3'd0, 32'd1);
    step();
    check("midrst.underflow", 32'(bus.underflow), 1);
    check("midrst.no_count", bus.pass_cnt + 32'(bus.err_cnt), 0);
    check_all("midrst");

    do_reset();
    issue(3'd0, 3'd2, 32'd5, 32'd7, 16'd0); step();
    issue(3'd1, 3'd1, 32'd3, 32'd5, 16'd0); step();
    issue(3'd7, 3'd0, 32'h1234, 32'h5678, 16'hBEEF); step();
    retire(3'd2, 32'd12); step();
    retire(3'd1, 32'hFFFFFFFE); step();
    retire(3'd0, 32'h0000BEEF); step();
    idle();
    check("inorder.pass", bus.pass_cnt, 3);
    check("inorder.err", 32'(bus.err_cnt), 0);
    check("inorder.checksum", bus.checksum, 32'hFFFF411D);
    check_all("inorder");

    vt[0] = '{3'd0, 32'd5,         32'd7,         16'd0,      32'd12};
    vt[1] = '{3'd1, 32'd3,         32'd5,         16'd0,      32'hFFFFFFFE};
    vt[2] = '{3'd2, 32'hF0F0FFFF,  32'h0FF00F0F,  16'd0,      32'h00F00F0F};
    vt[3] = '{3'd3, 32'h0F000000,  32'h000000F0,  16'd0,      32'h0F0000F0};
    vt[4] = '{3'd4, 32'hFFFFFFFF,  32'h0F0F0F0F,  16'd0,      32'hF0F0F0F0};
    vt[5] = '{3'd5, 32'd1,         32'h00000021,  16'd0,      32'd2};
    vt[6] = '{3'd6, 32'h80000000,  32'd31,        16'd0,      32'd1};
    vt[7] = '{3'd7, 32'hFFFFFFFF,  32'hFFFFFFFF,  16'hBEEF,   32'h0000BEEF};
    vt[8] = '{3'd5, 32'd3,         32'h00000040,  16'd0,      32'd3};
    do_reset();
    run_chk = 0;
    for (int i = 0; i < 9; i++) begin
      issue(vt[i].op, 3'(i), vt[i].a, vt[i].b, vt[i].imm);
      step();
      retire(3'(i), vt[i].exp);
      step();
      idle();
      run_chk ^= vt[i].exp;
      check($sformatf("vec%0d.pass", i), bus.pass_cnt, 32'(i + 1));
      check($sformatf("vec%0d.err", i), 32'(bus.err_cnt), 0);
    end
    check("vec.checksum", bus.checksum, run_chk);

    // value mismatch halts scoring; later correct retire is ignored
    do_reset();
    issue(3'd4, 3'd5, 32'hFFFFFFFF, 32'h0F0F0F0F, 16'd0); step();
    retire(3'd5, 32'hF0F0F0F1); step();
    idle();
    check("mis.err", 32'(bus.err_cnt), 1);
    check("mis.fe_exp", bus.first_err_exp, 32'hF0F0F0F0);
    check("mis.fe_got", bus.first_err_got, 32'hF0F0F0F1);
    check("mis.halted", 32'(bus.halted), 1);
    issue(3'd0, 3'd0, 32'd1, 32'd1, 16'd0); step();
    retire(3'd0, 32'd2); step();
    idle();
    check("mis.pass_frozen", bus.pass_cnt, 0);
    check("mis.chk_frozen", bus.checksum, 32'hF0F0F0F1);
    check("mis.in_flight", 32'(bus.in_flight), 0);
    check_all("mis");

    do_reset();
    issue(3'd0, 3'd3, 32'd10, 32'd20, 16'd0); step();
    retire(3'd4, 32'd30); step();
    idle();
    check("rdmis.err", 32'(bus.err_cnt), 1);
    check("rdmis.pass", bus.pass_cnt, 0);
    check_all("rdmis");

    do_reset();
    for (int i = 0; i < 4; i++) begin
      issue(3'd0, 3'(i), 32'(i), 32'(i), 16'd0);
      step();
    end
    idle();
    check("full.in_flight", 32'(bus.in_flight), 4);
    check("full.no_ovf", 32'(bus.overflow), 0);
    drive(1, 3'd0, 3'd4, 32'd4, 32'd4, 16'd0, 1, 3'd0, 32'd0);
    step();
    idle();
    check("full.swap_in_flight", 32'(bus.in_flight), 4);
    check("full.swap_no_ovf", 32'(bus.overflow), 0);
    check("full.swap_pass", bus.pass_cnt, 1);
    issue(3'd0, 3'd5, 32'd9, 32'd9, 16'd0); step();
    idle();
    check("full.ovf", 32'(bus.overflow), 1);
    check("full.ovf_in_flight", 32'(bus.in_flight), 4);
    check_all("full");

    do_reset();
    for (int c = 0; c < 1500; c++) begin
      logic [2:0] rrd;
      logic [31:0] rres;
      rst = ($urandom % 200) == 0;
      rrd = 3'($urandom);
      rres = $urandom;
      if (mq.size() != 0 && ($urandom % 60) != 0) begin
        rrd = mq[0].rd;
        rres = mq[0].v;
        if (($urandom % 80) == 0) rrd = rrd ^ 3'd1;
      end
      drive(1'($urandom), 3'($urandom), 3'($urandom), $urandom, $urandom, 16'($urandom),
            1'($urandom), rrd, rres);
      step();
      check_all("rand");
    end
    rst = 1'b0;
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
